// File: rtl/sfifo_fwft_stage_pkg.sv
// Shared definitions for the synchronous FIFO read-side output stage:
// legal read-latency range and a constant-friendly ceiling log2.
package sfifo_fwft_stage_pkg;

   localparam int RdLatencyMin = 1;
   localparam int RdLatencyMax = 2;

   // Smallest width w such that 2**w >= value; usable in parameter expressions.
   function automatic int clog2(input int value);
      int width;
      width = 0;
      while ((1 << width) < value) begin
         width++;
      end
      return width;
   endfunction

endpackage

// File: rtl/sfifo_skid_buf.sv
// Small circular skid buffer: Depth registered words, wrapping write/read
// indices and an occupancy count. The head word is always visible on rd_data.
module sfifo_skid_buf
   import sfifo_fwft_stage_pkg::*;
#(
   parameter int DataWidth = 8,
   parameter int Depth = 3,
   localparam int IdxWidth = (clog2(Depth) < 1) ? 1 : clog2(Depth),
   localparam int CntWidth = clog2(Depth + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 wr_en,
   input  logic [DataWidth-1:0] wr_data,
   input  logic                 rd_en,
   output logic [DataWidth-1:0] rd_data,
   output logic [CntWidth-1:0]  count
);

   localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(Depth - 1);
   localparam logic [CntWidth-1:0] FullCount = CntWidth'(Depth);

   logic [DataWidth-1:0] mem [Depth];
   logic [IdxWidth-1:0]  wr_idx;
   logic [IdxWidth-1:0]  rd_idx;

   // Storage is cleared on reset so the head word reads as zero until the first capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_idx <= '0;
         rd_idx <= '0;
         count  <= '0;
         for (int i = 0; i < Depth; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (wr_en) begin
            assert (count != FullCount);
            mem[wr_idx] <= wr_data;
            wr_idx      <= (wr_idx == LastIdx) ? '0 : wr_idx + 1'b1;
         end
         if (rd_en) begin
            assert (count != '0);
            rd_idx <= (rd_idx == LastIdx) ? '0 : rd_idx + 1'b1;
         end
         case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign rd_data = mem[rd_idx];

endmodule

// File: rtl/sfifo_fwft_stage.sv
// First-word-fall-through output stage: prefetches from a registered-read RAM
// using a credit scheme so the consumer sees one word per cycle without bubbles.
module sfifo_fwft_stage
   import sfifo_fwft_stage_pkg::*;
#(
   parameter int DataWidth = 8,
   parameter int RdLatency = 1,
   localparam int SkidDepth = RdLatency + 2,
   localparam int CntWidth = clog2(SkidDepth + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 FIFOEmpty,
   output logic                 FIFORdReq,
   input  logic [DataWidth-1:0] RdData,
   output logic [DataWidth-1:0] DataOut,
   output logic                 OutValid,
   input  logic                 OutReady,
   output logic [CntWidth-1:0]  BufCount
);

   localparam logic [CntWidth:0] CreditLimit = (CntWidth + 1)'(SkidDepth);
   localparam bit LatencyLegal = (RdLatency >= RdLatencyMin) && (RdLatency <= RdLatencyMax);

   logic [RdLatency-1:0] inflight;
   logic [CntWidth-1:0]  inflight_cnt;
   logic [CntWidth:0]    credit_used;
   logic                 issue;
   logic                 pop;
   logic                 capture;

   // Every word either buffered or still travelling through the RAM consumes a credit,
   // so a capture can never find the buffer full. OutReady deliberately plays no part here.
   assign inflight_cnt = CntWidth'($countones(inflight));
   assign credit_used  = {1'b0, BufCount} + {1'b0, inflight_cnt};
   assign FIFORdReq    = !reset && !FIFOEmpty && (credit_used < CreditLimit);
   assign issue        = FIFORdReq && !FIFOEmpty;
   assign capture      = inflight[RdLatency-1];
   assign OutValid     = (BufCount != '0);
   assign pop          = OutValid && OutReady;

   if (RdLatency == 1) begin : g_pipe_single
      always_ff @(posedge clk) begin
         if (reset) begin
            inflight <= '0;
         end else begin
            inflight <= issue;
         end
      end
   end else begin : g_pipe_multi
      always_ff @(posedge clk) begin
         if (reset) begin
            inflight <= '0;
         end else begin
            inflight <= {inflight[RdLatency-2:0], issue};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (LatencyLegal);
      end
   end

   sfifo_skid_buf #(
      .DataWidth(DataWidth),
      .Depth    (SkidDepth)
   ) u_skid_buf (
      .clk    (clk),
      .reset  (reset),
      .wr_en  (capture),
      .wr_data(RdData),
      .rd_en  (pop),
      .rd_data(DataOut),
      .count  (BufCount)
   );

endmodule

// File: tb/tb_sfifo_fwft_stage.sv
// Bench for sfifo_fwft_stage: RdLatency 1 and 2 instances share stimulus; each is
// checked every cycle against a queue-based model of issued, in-flight and buffered words.
module tb_sfifo_fwft_stage;

   logic       clk;
   logic       reset;
   logic       fifo_empty;
   logic       out_ready;
   logic [7:0] reset_word;
   int         chk_point;
   int         cyc;
   int         compare_count;
   int         mismatch_count;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compare_count++;
      if (observed !== expected) begin
         mismatch_count++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, observed, expected, cyc);
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic emp, input logic rdy,
                                input int cycles, input int chk);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         reset      = rst;
         fifo_empty = emp;
         out_ready  = rdy;
         chk_point  = (i == cycles - 1) ? chk : 0;
      end
   endtask

   for (genvar k = 0; k < 2; k++) begin : g
      localparam int Lat = k + 1;
      localparam int Depth = Lat + 2;
      localparam int CntW = (k == 0) ? 2 : 3;

      logic            rd_req;
      logic            valid;
      logic [7:0]      rd_data;
      logic [7:0]      data_out;
      logic [CntW-1:0] count;

      sfifo_fwft_stage #(
         .DataWidth(8),
         .RdLatency(Lat)
      ) dut (
         .clk      (clk),
         .reset    (reset),
         .FIFOEmpty(fifo_empty),
         .FIFORdReq(rd_req),
         .RdData   (rd_data),
         .DataOut  (data_out),
         .OutValid (valid),
         .OutReady (out_ready),
         .BufCount (count)
      );

      // RAM side: registered read that returns a word Lat cycles after an accepted read.
      logic [7:0] ram_pipe [2] = '{8'hEE, 8'hEE};
      logic [7:0] next_word = 8'h11;
      assign rd_data = ram_pipe[Lat-1];

      logic [7:0] bufq [$];
      logic [7:0] fl_word [$];
      int         fl_due [$];
      bit         exp_rdreq;
      bit         exp_issue = 1'b0;
      bit         act_issue = 1'b0;
      bit         exp_pop = 1'b0;
      bit         reset_s = 1'b1;
      bit         clean = 1'b1;
      int         issue_cnt = 0;
      int         pop_cnt = 0;
      int         first_issue = -1;
      int         first_valid = -1;
      logic [7:0] last_pop = 8'h00;

      always @(negedge clk) begin
         #2;
         exp_rdreq = !reset && !fifo_empty && ((bufq.size() + fl_word.size()) < Depth);
         checkOutput($sformatf("L%0d rd_req", Lat), 32'(rd_req), 32'(exp_rdreq));
         checkOutput($sformatf("L%0d out_valid", Lat), 32'(valid), 32'(bufq.size() != 0));
         checkOutput($sformatf("L%0d buf_count", Lat), 32'(count), 32'(bufq.size()));
         if (bufq.size() != 0) begin
            checkOutput($sformatf("L%0d data_out", Lat), 32'(data_out), 32'(bufq[0]));
         end else if (clean) begin
            checkOutput($sformatf("L%0d data_out reset", Lat), 32'(data_out), 32'h0);
         end
         exp_issue = exp_rdreq;
         act_issue = rd_req && !fifo_empty;
         exp_pop   = (bufq.size() != 0) && out_ready;
         reset_s   = reset;
         if (act_issue && first_issue < 0) first_issue = cyc;
         if (valid && first_valid < 0) first_valid = cyc;
         case (chk_point)
            1: checkOutput($sformatf("L%0d first valid latency", Lat),
                           32'(first_valid - first_issue), 32'(Lat + 1));
            2: begin
               checkOutput($sformatf("L%0d backpressure issues", Lat), 32'(issue_cnt), 32'(Depth));
               checkOutput($sformatf("L%0d backpressure count", Lat), 32'(count), 32'(Depth));
               checkOutput($sformatf("L%0d backpressure head", Lat), 32'(data_out), 32'h11);
            end
            3: begin
               checkOutput($sformatf("L%0d single word pops", Lat), 32'(pop_cnt), 32'd1);
               checkOutput($sformatf("L%0d single word value", Lat), 32'(last_pop), 32'hA5);
               checkOutput($sformatf("L%0d single word drained", Lat), 32'(valid), 32'd0);
            end
            5: begin
               checkOutput($sformatf("L%0d post-reset pops", Lat), 32'(pop_cnt), 32'd0);
               checkOutput($sformatf("L%0d post-reset count", Lat), 32'(count), 32'd0);
            end
            default: ;
         endcase
      end

      // After each edge: advance the RAM, then move words between the model's queues.
      always @(posedge clk) begin
         logic [7:0] word_issued;
         #1;
         word_issued = next_word;
         ram_pipe[1] = ram_pipe[0];
         ram_pipe[0] = act_issue ? next_word : 8'hEE;
         if (act_issue) next_word = next_word + 8'h11;
         if (reset_s) begin
            next_word = reset_word;
            bufq.delete();
            fl_word.delete();
            fl_due.delete();
            clean       = 1'b1;
            issue_cnt   = 0;
            pop_cnt     = 0;
            first_issue = -1;
            first_valid = -1;
            last_pop    = 8'h00;
         end else begin
            if (exp_pop) begin
               last_pop = bufq.pop_front();
               pop_cnt++;
            end
            while (fl_due.size() != 0 && fl_due[0] == cyc) begin
               bufq.push_back(fl_word.pop_front());
               void'(fl_due.pop_front());
               clean = 1'b0;
            end
            if (exp_issue) begin
               fl_word.push_back(word_issued);
               fl_due.push_back(cyc + Lat);
               issue_cnt++;
            end
         end
      end
   end

   initial begin
      reset          = 1'b1;
      fifo_empty     = 1'b0;
      out_ready      = 1'b1;
      chk_point      = 0;
      cyc            = 0;
      compare_count  = 0;
      mismatch_count = 0;
      reset_word     = 8'h11;

      // Continuous stream with the consumer always ready.
      applyStimulus(1'b1, 1'b0, 1'b1, 3, 0);
      applyStimulus(1'b0, 1'b0, 1'b1, 12, 1);

      // Consumer stalled, then released.
      applyStimulus(1'b1, 1'b0, 1'b0, 2, 0);
      applyStimulus(1'b0, 1'b0, 1'b0, 10, 2);
      applyStimulus(1'b0, 1'b0, 1'b1, 12, 0);

      // Empty FIFO, then exactly one word.
      reset_word = 8'hA5;
      applyStimulus(1'b1, 1'b1, 1'b1, 2, 0);
      applyStimulus(1'b0, 1'b1, 1'b1, 5, 0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1, 0);
      applyStimulus(1'b0, 1'b1, 1'b1, 8, 3);

      // Reset while words are buffered and in flight; late RAM data must be dropped.
      reset_word = 8'h11;
      applyStimulus(1'b1, 1'b0, 1'b0, 2, 0);
      applyStimulus(1'b0, 1'b0, 1'b0, 3, 0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1, 0);
      applyStimulus(1'b0, 1'b1, 1'b1, 6, 5);

      // Random empty/ready traffic with occasional resets.
      for (int n = 0; n < 4000; n++) begin
         applyStimulus(($urandom_range(0, 399) == 0), ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 2) != 0), 1, 0);
      end

      @(negedge clk);
      #5;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
      $finish;
   end

endmodule
